// File: rtl/int_issue_queue.sv
// int_issue_queue: collapsing integer ALU reservation queue.
// Entry 0 is always the oldest. Pending operands are captured from the CDB by tag.
// The oldest entry with both operands ready is presented to the issue unit.
// Optional build macro ISSUEQ_WAKEUP_BYPASS_EN: an entry woken by the CDB this
// cycle can be presented in the same cycle, with its operand taken from cdb_out.
module int_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dispatch_en,
    input  logic [3:0]  dispatch_opcode,
    input  logic [31:0] dispatch_rsdata,
    input  logic [5:0]  dispatch_rstag,
    input  logic        dispatch_rsvalid,
    input  logic [31:0] dispatch_rtdata,
    input  logic [5:0]  dispatch_rttag,
    input  logic        dispatch_rtvalid,
    input  logic [5:0]  dispatch_rdtag,
    output logic        queue_full,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tagout,
    input  logic [31:0] cdb_out,
    input  logic        flush,
    output logic        ready_int,
    input  logic        issue_int,
    output logic [3:0]  opcode,
    output logic [31:0] rsdata,
    output logic [31:0] rtdata,
    output logic [5:0]  rdtag
);

    // Stored entries
    logic [DEPTH-1:0] valid_q, rs_vld_q, rt_vld_q;
    logic [3:0]       opcode_q  [DEPTH];
    logic [31:0]      rs_data_q [DEPTH];
    logic [31:0]      rt_data_q [DEPTH];
    logic [5:0]       rs_tag_q  [DEPTH];
    logic [5:0]       rt_tag_q  [DEPTH];
    logic [5:0]       rdtag_q   [DEPTH];
    logic [CNT_W-1:0] count_q;

    // Entries with this cycle's wakeup applied. Slot DEPTH is a permanently
    // empty entry so the collapse can read i+1 without a range check.
    logic [DEPTH:0]   w_valid, w_rs_vld, w_rt_vld;
    logic [3:0]       w_opcode  [DEPTH+1];
    logic [31:0]      w_rs_data [DEPTH+1];
    logic [31:0]      w_rt_data [DEPTH+1];
    logic [5:0]       w_rs_tag  [DEPTH+1];
    logic [5:0]       w_rt_tag  [DEPTH+1];
    logic [5:0]       w_rdtag   [DEPTH+1];
    logic [DEPTH-1:0] rs_hit, rt_hit;

    // Next-state entries
    logic [DEPTH-1:0] n_valid, n_rs_vld, n_rt_vld;
    logic [3:0]       n_opcode  [DEPTH];
    logic [31:0]      n_rs_data [DEPTH];
    logic [31:0]      n_rt_data [DEPTH];
    logic [5:0]       n_rs_tag  [DEPTH];
    logic [5:0]       n_rt_tag  [DEPTH];
    logic [5:0]       n_rdtag   [DEPTH];
    logic [CNT_W-1:0] count_nxt;

    logic [DEPTH-1:0] cand;
    logic [CNT_W-1:0] sel_idx;
    logic             do_issue, disp_ok;
    logic [CNT_W-1:0] wr_idx;
    logic             d_rs_hit, d_rt_hit;

    // CDB snoop: merge a matching broadcast into each pending operand
    always_comb begin
        w_valid  = '0;
        w_rs_vld = '0;
        w_rt_vld = '0;
        rs_hit   = '0;
        rt_hit   = '0;
        for (int i = 0; i <= DEPTH; i++) begin
            w_opcode[i]  = '0;
            w_rs_data[i] = '0;
            w_rt_data[i] = '0;
            w_rs_tag[i]  = '0;
            w_rt_tag[i]  = '0;
            w_rdtag[i]   = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            rs_hit[i]    = cdb_valid && !rs_vld_q[i] && (rs_tag_q[i] == cdb_tagout);
            rt_hit[i]    = cdb_valid && !rt_vld_q[i] && (rt_tag_q[i] == cdb_tagout);
            w_valid[i]   = valid_q[i];
            w_rs_vld[i]  = rs_vld_q[i] | rs_hit[i];
            w_rt_vld[i]  = rt_vld_q[i] | rt_hit[i];
            w_rs_data[i] = rs_hit[i] ? cdb_out : rs_data_q[i];
            w_rt_data[i] = rt_hit[i] ? cdb_out : rt_data_q[i];
            w_opcode[i]  = opcode_q[i];
            w_rs_tag[i]  = rs_tag_q[i];
            w_rt_tag[i]  = rt_tag_q[i];
            w_rdtag[i]   = rdtag_q[i];
        end
    end

`ifdef ISSUEQ_WAKEUP_BYPASS_EN
    assign cand = w_valid[DEPTH-1:0] & w_rs_vld[DEPTH-1:0] & w_rt_vld[DEPTH-1:0];
`else
    assign cand = valid_q & rs_vld_q & rt_vld_q;
`endif

    // Pick the oldest issuable entry and present it. The woken copies equal
    // the stored values for any entry that was already fully ready, so the
    // same data path serves both build variants.
    always_comb begin
        ready_int = 1'b0;
        sel_idx   = '0;
        opcode    = '0;
        rsdata    = '0;
        rtdata    = '0;
        rdtag     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                ready_int = 1'b1;
                sel_idx   = CNT_W'(i);
            end
        end
        if (ready_int) begin
            opcode = w_opcode[sel_idx];
            rsdata = w_rs_data[sel_idx];
            rtdata = w_rt_data[sel_idx];
            rdtag  = w_rdtag[sel_idx];
        end
    end

    assign do_issue = ready_int & issue_int;
    assign disp_ok  = dispatch_en & ~queue_full;
    assign wr_idx   = do_issue ? (count_q - CNT_W'(1)) : count_q;
    assign d_rs_hit = cdb_valid && !dispatch_rsvalid && (dispatch_rstag == cdb_tagout);
    assign d_rt_hit = cdb_valid && !dispatch_rtvalid && (dispatch_rttag == cdb_tagout);

    // Collapse past the issued entry, append the dispatch, then apply flush
    always_comb begin
        n_valid  = '0;
        n_rs_vld = '0;
        n_rt_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            int src;
            src = (do_issue && (CNT_W'(i) >= sel_idx)) ? i + 1 : i;
            n_valid[i]   = w_valid[src];
            n_rs_vld[i]  = w_rs_vld[src];
            n_rt_vld[i]  = w_rt_vld[src];
            n_opcode[i]  = w_opcode[src];
            n_rs_data[i] = w_rs_data[src];
            n_rt_data[i] = w_rt_data[src];
            n_rs_tag[i]  = w_rs_tag[src];
            n_rt_tag[i]  = w_rt_tag[src];
            n_rdtag[i]   = w_rdtag[src];
            if (disp_ok && (CNT_W'(i) == wr_idx)) begin
                n_valid[i]   = 1'b1;
                n_opcode[i]  = dispatch_opcode;
                n_rs_vld[i]  = dispatch_rsvalid | d_rs_hit;
                n_rt_vld[i]  = dispatch_rtvalid | d_rt_hit;
                n_rs_data[i] = d_rs_hit ? cdb_out : dispatch_rsdata;
                n_rt_data[i] = d_rt_hit ? cdb_out : dispatch_rtdata;
                n_rs_tag[i]  = dispatch_rstag;
                n_rt_tag[i]  = dispatch_rttag;
                n_rdtag[i]   = dispatch_rdtag;
            end
        end
        count_nxt = count_q + CNT_W'(disp_ok) - CNT_W'(do_issue);
        if (flush) begin
            n_valid   = '0;
            count_nxt = '0;
        end
    end

    // Entry storage, occupancy count and registered full flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            rs_vld_q   <= '0;
            rt_vld_q   <= '0;
            opcode_q   <= '{default: '0};
            rs_data_q  <= '{default: '0};
            rt_data_q  <= '{default: '0};
            rs_tag_q   <= '{default: '0};
            rt_tag_q   <= '{default: '0};
            rdtag_q    <= '{default: '0};
            count_q    <= '0;
            queue_full <= 1'b0;
        end else begin
            valid_q    <= n_valid;
            rs_vld_q   <= n_rs_vld;
            rt_vld_q   <= n_rt_vld;
            opcode_q   <= n_opcode;
            rs_data_q  <= n_rs_data;
            rt_data_q  <= n_rt_data;
            rs_tag_q   <= n_rs_tag;
            rt_tag_q   <= n_rt_tag;
            rdtag_q    <= n_rdtag;
            count_q    <= count_nxt;
            queue_full <= (count_nxt == CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_int_issue_queue.sv
// Bench for int_issue_queue: expected issue results are queued as stimulus is
// driven and compared as each entry is granted.
module tb_int_issue_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_en;
    logic [3:0]  dispatch_opcode;
    logic [31:0] dispatch_rsdata;
    logic [5:0]  dispatch_rstag;
    logic        dispatch_rsvalid;
    logic [31:0] dispatch_rtdata;
    logic [5:0]  dispatch_rttag;
    logic        dispatch_rtvalid;
    logic [5:0]  dispatch_rdtag;
    logic        queue_full;
    logic        cdb_valid;
    logic [5:0]  cdb_tagout;
    logic [31:0] cdb_out;
    logic        flush;
    logic        ready_int;
    logic        issue_int;
    logic [3:0]  opcode;
    logic [31:0] rsdata;
    logic [31:0] rtdata;
    logic [5:0]  rdtag;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [5:0]  rd;
    } exp_t;
    exp_t exp_q[$];

    int_issue_queue #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .dispatch_en(dispatch_en), .dispatch_opcode(dispatch_opcode),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rstag(dispatch_rstag),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rttag(dispatch_rttag), .dispatch_rtvalid(dispatch_rtvalid),
        .dispatch_rdtag(dispatch_rdtag), .queue_full(queue_full),
        .cdb_valid(cdb_valid), .cdb_tagout(cdb_tagout), .cdb_out(cdb_out),
        .flush(flush), .ready_int(ready_int), .issue_int(issue_int),
        .opcode(opcode), .rsdata(rsdata), .rtdata(rtdata), .rdtag(rdtag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [31:0] rs, input logic rsv,
                            input logic [5:0] rstag, input logic [31:0] rt, input logic rtv,
                            input logic [5:0] rttag, input logic [5:0] rd);
        dispatch_en      = 1'b1;
        dispatch_opcode  = op;
        dispatch_rsdata  = rs;
        dispatch_rsvalid = rsv;
        dispatch_rstag   = rstag;
        dispatch_rtdata  = rt;
        dispatch_rtvalid = rtv;
        dispatch_rttag   = rttag;
        dispatch_rdtag   = rd;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] rs, input logic rsv,
                        input logic [5:0] rstag, input logic [31:0] rt, input logic rtv,
                        input logic [5:0] rttag, input logic [5:0] rd);
        set_disp(op, rs, rsv, rstag, rt, rtv, rttag, rd);
        cyc();
        dispatch_en = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] op, input logic [31:0] rs,
                            input logic [31:0] rt, input logic [5:0] rd);
        exp_t e;
        e.op = op; e.rs = rs; e.rt = rt; e.rd = rd;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for a presented entry, compare it with the oldest
    // expectation and grant it for one cycle.
    task automatic pop_issue(input string tag);
        int   n;
        exp_t e;
        n = 0;
        #1;
        while (!ready_int && n < 20) begin
            cyc();
            n++;
        end
        if (!ready_int) begin
            chk({tag, "_timeout"}, 32'(ready_int), 32'd1);
        end else if (exp_q.size() == 0) begin
            chk({tag, "_unexpected"}, 32'(ready_int), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_rd"}, 32'(rdtag), 32'(e.rd));
            chk({tag, "_op"}, 32'(opcode), 32'(e.op));
            chk({tag, "_rs"}, rsdata, e.rs);
            chk({tag, "_rt"}, rtdata, e.rt);
            issue_int = 1'b1;
            cyc();
            issue_int = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; dispatch_en = 1'b0; dispatch_opcode = '0; dispatch_rsdata = '0;
        dispatch_rstag = '0; dispatch_rsvalid = 1'b0; dispatch_rtdata = '0;
        dispatch_rttag = '0; dispatch_rtvalid = 1'b0; dispatch_rdtag = '0;
        cdb_valid = 1'b0; cdb_tagout = '0; cdb_out = '0; flush = 1'b0; issue_int = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        #1;
        chk("por_ready", 32'(ready_int), 32'd0);
        chk("por_full", 32'(queue_full), 32'd0);
        chk("por_rdtag", 32'(rdtag), 32'd0);

        // Mid-run reset with a full queue discards everything immediately
        for (int i = 0; i < 4; i++)
            disp(4'(i + 1), 32'(16 + i), 1'b1, 6'd0, 32'(32 + i), 1'b1, 6'd0, 6'(1 + i));
        chk("pre_rst_full", 32'(queue_full), 32'd1);
        chk("pre_rst_ready", 32'(ready_int), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(ready_int), 32'd0);
        chk("rst_full", 32'(queue_full), 32'd0);
        chk("rst_rsdata", rsdata, 32'd0);
        chk("rst_rdtag", 32'(rdtag), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        chk("rst_after_ready", 32'(ready_int), 32'd0);
        disp(4'h2, 32'd5, 1'b1, 6'd0, 32'd7, 1'b1, 6'd0, 6'd9);
        chk("rel_lat_ready", 32'(ready_int), 32'd1);
        push_exp(4'h2, 32'd5, 32'd7, 6'd9);
        pop_issue("rel");
        chk("rel_empty", 32'(ready_int), 32'd0);

        // Fill, dropped dispatch while full (also with a same-cycle issue)
        for (int i = 0; i < 4; i++) begin
            disp(4'(i + 3), 32'(256 + i), 1'b1, 6'd0, 32'(512 + i), 1'b1, 6'd0, 6'(10 + i));
            push_exp(4'(i + 3), 32'(256 + i), 32'(512 + i), 6'(10 + i));
        end
        chk("fill_full", 32'(queue_full), 32'd1);
        disp(4'hE, 32'd99, 1'b1, 6'd0, 32'd98, 1'b1, 6'd0, 6'd15);
        chk("drop_full", 32'(queue_full), 32'd1);
        set_disp(4'hE, 32'd97, 1'b1, 6'd0, 32'd96, 1'b1, 6'd0, 6'd16);
        pop_issue("fill0");
        dispatch_en = 1'b0;
        chk("drop_issue_full", 32'(queue_full), 32'd0);
        pop_issue("fill1");
        pop_issue("fill2");
        pop_issue("fill3");
        chk("fill_empty", 32'(ready_int), 32'd0);

        // Out-of-order issue and CDB wakeup
        disp(4'h3, 32'hBAD, 1'b0, 6'd12, 32'd3, 1'b1, 6'd0, 6'd20);
        disp(4'h4, 32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd21);
        push_exp(4'h4, 32'd1, 32'd2, 6'd21);
        pop_issue("ooo_e1");
        chk("ooo_wait", 32'(ready_int), 32'd0);
        cdb_valid = 1'b1; cdb_tagout = 6'd12; cdb_out = 32'hDEAD;
        #1;
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
        chk("ooo_byp_ready", 32'(ready_int), 32'd1);
        chk("ooo_byp_rs", rsdata, 32'hDEAD);
`else
        chk("ooo_noby_ready", 32'(ready_int), 32'd0);
`endif
        cyc();
        cdb_valid = 1'b0;
        #1;
        chk("ooo_wake_ready", 32'(ready_int), 32'd1);
        chk("ooo_wake_rs", rsdata, 32'hDEAD);
        push_exp(4'h3, 32'hDEAD, 32'd3, 6'd20);
        pop_issue("ooo_e0");

        // Dispatch racing a matching broadcast
        set_disp(4'h5, 32'd0, 1'b0, 6'd20, 32'd8, 1'b1, 6'd0, 6'd30);
        cdb_valid = 1'b1; cdb_tagout = 6'd20; cdb_out = 32'h55;
        #1;
        chk("race_same_cyc", 32'(ready_int), 32'd0);
        cyc();
        dispatch_en = 1'b0; cdb_valid = 1'b0;
        #1;
        chk("race_ready", 32'(ready_int), 32'd1);
        push_exp(4'h5, 32'h55, 32'd8, 6'd30);
        pop_issue("race");

        // Both operands woken by one broadcast
        disp(4'hC, 32'd0, 1'b0, 6'd33, 32'd0, 1'b0, 6'd33, 6'd50);
        cdb_valid = 1'b1; cdb_tagout = 6'd33; cdb_out = 32'h1234;
        cyc();
        cdb_valid = 1'b0;
        push_exp(4'hC, 32'h1234, 32'h1234, 6'd50);
        pop_issue("both");

        // Issue from the middle while dispatching: order becomes A, C, D
        disp(4'h6, 32'd0, 1'b0, 6'd50, 32'h11, 1'b1, 6'd0, 6'd40);
        disp(4'h7, 32'h21, 1'b1, 6'd0, 32'h22, 1'b1, 6'd0, 6'd41);
        disp(4'h8, 32'h31, 1'b1, 6'd0, 32'h32, 1'b1, 6'd0, 6'd42);
        push_exp(4'h7, 32'h21, 32'h22, 6'd41);
        set_disp(4'h9, 32'h41, 1'b1, 6'd0, 32'h42, 1'b1, 6'd0, 6'd43);
        pop_issue("col_b");
        dispatch_en = 1'b0;
        chk("col_cnt3_notfull", 32'(queue_full), 32'd0);
        set_disp(4'hA, 32'h51, 1'b1, 6'd0, 32'h52, 1'b1, 6'd0, 6'd44);
        cdb_valid = 1'b1; cdb_tagout = 6'd50; cdb_out = 32'h77;
        cyc();
        dispatch_en = 1'b0; cdb_valid = 1'b0;
        #1;
        chk("col_cnt4_full", 32'(queue_full), 32'd1);
        push_exp(4'h6, 32'h77, 32'h11, 6'd40);
        push_exp(4'h8, 32'h31, 32'h32, 6'd42);
        push_exp(4'h9, 32'h41, 32'h42, 6'd43);
        push_exp(4'hA, 32'h51, 32'h52, 6'd44);
        pop_issue("col_a");
        pop_issue("col_c");
        pop_issue("col_d");
        pop_issue("col_e");
        chk("col_empty", 32'(ready_int), 32'd0);

        // Flush wins over concurrent dispatch and issue
        disp(4'h1, 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd60);
        disp(4'h1, 32'd2, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd61);
        set_disp(4'h1, 32'd3, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 6'd62);
        issue_int = 1'b1;
        flush = 1'b1;
        cyc();
        dispatch_en = 1'b0; issue_int = 1'b0; flush = 1'b0;
        #1;
        chk("flush_ready", 32'(ready_int), 32'd0);
        chk("flush_full", 32'(queue_full), 32'd0);
        chk("flush_rdtag", 32'(rdtag), 32'd0);
        cyc();
        chk("flush_hold", 32'(ready_int), 32'd0);
        disp(4'hF, 32'hAA, 1'b1, 6'd0, 32'hBB, 1'b1, 6'd0, 6'd63);
        push_exp(4'hF, 32'hAA, 32'hBB, 6'd63);
        pop_issue("post_flush");
        chk("final_empty", 32'(ready_int), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
